// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector with a saturating hit counter
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             data_i,
  input  logic             clr_cnt_i,
  output logic             flag_hit_o,
  output logic [CNT_W-1:0] match_cnt_o
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  logic [PAT_W-1:0] win_q, win_d;
  logic [FW-1:0] fill_q, fill_d, fill_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic flag_q, hit_d;
  // hit is gated by en so a held full window cannot re-fire during gaps
  always_comb begin
    win_d = en_i ? {win_q[PAT_W-2:0], data_i} : win_q;
    fill_n = (en_i && fill_q != FULL) ? fill_q + FW'(1) : fill_q;
    hit_d = en_i && win_d == PATTERN && fill_n == FULL;
    fill_d = (hit_d && !OVERLAP) ? '0 : fill_n;
    cnt_d = clr_cnt_i ? '0 : (hit_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      flag_q <= 1'b0;
    end else begin
      win_q <= win_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      flag_q <= hit_d;
    end
  end
  assign flag_hit_o = flag_q;
  assign match_cnt_o = cnt_q;
endmodule
